// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage MIPS core.
// Carries instruction, PC, exception code, delay-slot flag, valid and an
// opaque sideband payload. Supports stall, bubble insertion, flush, and
// merging of in-stage exceptions. Also keeps a saturating bubble counter.
module pipe_stage_reg #(
    parameter int          INS_W             = 32,
    parameter int          PC_W              = 32,
    parameter int          EXTRA_W           = 1,
    parameter logic [31:0] RESET_PC          = 32'h0000_3000,
    parameter logic [31:0] FLUSH_PC          = 32'h0000_4180,
    parameter bit          KEEP_PC_ON_BUBBLE = 1'b1,
    parameter int          CNT_W             = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               bubble,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [INS_W-1:0]   in_ins,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [4:0]         in_exccode,
    input  logic               in_bd,
    input  logic [EXTRA_W-1:0] in_extra,
    input  logic [4:0]         stage_exccode,
    output logic               out_valid,
    output logic [INS_W-1:0]   out_ins,
    output logic [PC_W-1:0]    out_pc,
    output logic [4:0]         out_exccode,
    output logic               out_bd,
    output logic [EXTRA_W-1:0] out_extra,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam logic [PC_W-1:0] RST_PC_W   = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] FLUSH_PC_W = PC_W'(FLUSH_PC);

    logic [4:0] merged_exc;

    // Earlier-stage exception wins over the in-stage one; empty slots carry none.
    always_comb begin
        merged_exc = 5'd0;
        if (in_valid) begin
            merged_exc = (in_exccode != 5'd0) ? in_exccode : stage_exccode;
        end
    end

    // Stage payload register: flush > stall > bubble > load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_ins     <= '0;
            out_pc      <= RST_PC_W;
            out_exccode <= 5'd0;
            out_bd      <= 1'b0;
            out_extra   <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_ins     <= '0;
            out_pc      <= FLUSH_PC_W;
            out_exccode <= 5'd0;
            out_bd      <= 1'b0;
            out_extra   <= '0;
        end else if (stall) begin
            out_valid   <= out_valid;
            out_ins     <= out_ins;
            out_pc      <= out_pc;
            out_exccode <= out_exccode;
            out_bd      <= out_bd;
            out_extra   <= out_extra;
        end else if (bubble) begin
            // A kept PC lets CP0 report the macroscopic PC if an interrupt lands on the bubble.
            out_valid   <= 1'b0;
            out_ins     <= '0;
            out_exccode <= 5'd0;
            out_extra   <= '0;
            if (KEEP_PC_ON_BUBBLE) begin
                out_pc <= in_pc;
                out_bd <= in_bd;
            end else begin
                out_pc <= RST_PC_W;
                out_bd <= 1'b0;
            end
        end else begin
            out_valid   <= in_valid;
            out_ins     <= in_ins;
            out_pc      <= in_pc;
            out_exccode <= merged_exc;
            out_bd      <= in_bd;
            out_extra   <= in_extra;
        end
    end

    // Saturating count of bubbles actually taken; flush does not clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (!flush && !stall && bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table for the single-edge
// behaviour plus hand sequences for async reset, KEEP_PC_ON_BUBBLE=0 and
// counter saturation with CNT_W=2.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, stall, bubble, flush, in_valid, in_bd;
    logic [31:0] in_ins, in_pc;
    logic [4:0]  in_exccode, stage_exccode;
    logic [0:0]  in_extra;

    logic        out_valid, out_bd;
    logic [31:0] out_ins, out_pc;
    logic [4:0]  out_exccode;
    logic [0:0]  out_extra;
    logic [15:0] bubble_cnt;

    logic        k0_valid, k0_bd;
    logic [31:0] k0_ins, k0_pc;
    logic [4:0]  k0_exc;
    logic [0:0]  k0_extra;
    logic [15:0] k0_cnt;

    logic        c2_valid, c2_bd;
    logic [31:0] c2_ins, c2_pc;
    logic [4:0]  c2_exc;
    logic [0:0]  c2_extra;
    logic [1:0]  c2_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
        .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc), .in_exccode(in_exccode),
        .in_bd(in_bd), .in_extra(in_extra), .stage_exccode(stage_exccode),
        .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc),
        .out_exccode(out_exccode), .out_bd(out_bd), .out_extra(out_extra),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.KEEP_PC_ON_BUBBLE(1'b0)) dut_k0 (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
        .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc), .in_exccode(in_exccode),
        .in_bd(in_bd), .in_extra(in_extra), .stage_exccode(stage_exccode),
        .out_valid(k0_valid), .out_ins(k0_ins), .out_pc(k0_pc),
        .out_exccode(k0_exc), .out_bd(k0_bd), .out_extra(k0_extra),
        .bubble_cnt(k0_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
        .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc), .in_exccode(in_exccode),
        .in_bd(in_bd), .in_extra(in_extra), .stage_exccode(stage_exccode),
        .out_valid(c2_valid), .out_ins(c2_ins), .out_pc(c2_pc),
        .out_exccode(c2_exc), .out_bd(c2_bd), .out_extra(c2_extra),
        .bubble_cnt(c2_cnt)
    );

    typedef struct {
        bit          stall, bubble, flush, iv;
        logic [31:0] ins, pc;
        logic [4:0]  exc, sexc;
        bit          bd, ex;
        bit          ev;
        logic [31:0] eins, epc;
        logic [4:0]  eexc;
        bit          ebd, eex;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vec [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit b, input bit f, input bit iv,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input logic [4:0] exc, input logic [4:0] sexc,
                         input bit bd, input bit ex);
        stall = s; bubble = b; flush = f; in_valid = iv; in_ins = ins; in_pc = pc;
        in_exccode = exc; stage_exccode = sexc; in_bd = bd; in_extra = ex;
    endtask

    task automatic check_all(input string tag, input bit ev, input logic [31:0] eins,
                             input logic [31:0] epc, input logic [4:0] eexc,
                             input bit ebd, input bit eex, input logic [15:0] ecnt);
        check({tag, ".valid"}, 64'(out_valid), 64'(ev));
        check({tag, ".ins"},   64'(out_ins), 64'(eins));
        check({tag, ".pc"},    64'(out_pc), 64'(epc));
        check({tag, ".exc"},   64'(out_exccode), 64'(eexc));
        check({tag, ".bd"},    64'(out_bd), 64'(ebd));
        check({tag, ".extra"}, 64'(out_extra), 64'(eex));
        check({tag, ".cnt"},   64'(bubble_cnt), 64'(ecnt));
    endtask

    initial begin
        //            st b  f  iv ins           pc     exc sexc bd ex  ev eins          epc           eexc ebd eex cnt
        vec[0]  = '{0, 0, 0, 1, 32'h2408_0005, 32'h3004, 0, 10, 1, 1, 1, 32'h2408_0005, 32'h3004, 10, 1, 1, 0};
        vec[1]  = '{0, 0, 0, 1, 32'h2408_0005, 32'h3004, 4, 10, 1, 1, 1, 32'h2408_0005, 32'h3004, 4, 1, 1, 0};
        vec[2]  = '{0, 0, 0, 0, 32'h0000_0001, 32'h3008, 4, 10, 0, 0, 0, 32'h0000_0001, 32'h3008, 0, 0, 0, 0};
        vec[3]  = '{0, 0, 0, 1, 32'h8C01_0004, 32'h300C, 0, 0, 0, 1, 1, 32'h8C01_0004, 32'h300C, 0, 0, 1, 0};
        vec[4]  = '{1, 0, 0, 1, 32'hAAAA_0001, 32'h3100, 7, 3, 1, 0, 1, 32'h8C01_0004, 32'h300C, 0, 0, 1, 0};
        vec[5]  = '{1, 1, 0, 0, 32'hAAAA_0002, 32'h3104, 0, 5, 1, 0, 1, 32'h8C01_0004, 32'h300C, 0, 0, 1, 0};
        vec[6]  = '{1, 0, 0, 1, 32'hAAAA_0003, 32'h3108, 2, 0, 1, 0, 1, 32'h8C01_0004, 32'h300C, 0, 0, 1, 0};
        vec[7]  = '{0, 1, 0, 1, 32'hFFFF_FFFF, 32'h3010, 3, 6, 1, 1, 0, 32'h0000_0000, 32'h3010, 0, 1, 0, 1};
        vec[8]  = '{1, 1, 1, 1, 32'h1111_1111, 32'h3020, 3, 6, 1, 1, 0, 32'h0000_0000, 32'h4180, 0, 0, 0, 1};
        vec[9]  = '{0, 0, 0, 1, 32'h0000_0020, 32'h3014, 0, 12, 0, 0, 1, 32'h0000_0020, 32'h3014, 12, 0, 0, 1};
        vec[10] = '{0, 1, 0, 1, 32'h0000_0024, 32'h3018, 0, 0, 0, 1, 0, 32'h0000_0000, 32'h3018, 0, 0, 0, 2};
        vec[11] = '{0, 0, 1, 1, 32'h0000_0028, 32'h301C, 0, 0, 1, 1, 0, 32'h0000_0000, 32'h4180, 0, 0, 0, 2};

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_all("reset", 0, 32'h0, 32'h3000, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vec[i].stall, vec[i].bubble, vec[i].flush, vec[i].iv, vec[i].ins, vec[i].pc,
                  vec[i].exc, vec[i].sexc, vec[i].bd, vec[i].ex);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vec[i].ev, vec[i].eins, vec[i].epc, vec[i].eexc,
                      vec[i].ebd, vec[i].eex, vec[i].ecnt);
        end

        // Asynchronous reset between edges with a live instruction loaded.
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h1234_5678, 32'h3040, 0, 0, 1, 1);
        @(posedge clk);
        #1;
        check("async.pre_ins", 64'(out_ins), 64'h1234_5678);
        #2;
        reset = 1'b1;
        #1;
        check_all("async", 0, 32'h0, 32'h3000, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Reset during a stall wins immediately; normal loading resumes after release.
        drive(0, 0, 0, 1, 32'h0BAD_F00D, 32'h3050, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all("rst_stall", 0, 32'h0, 32'h3000, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 1, 32'hCAFE_0001, 32'h3060, 0, 9, 0, 0);
        @(posedge clk);
        #1;
        check_all("post_rst", 1, 32'hCAFE_0001, 32'h3060, 9, 0, 0, 0);

        // KEEP_PC_ON_BUBBLE=0 instance loads RESET_PC and bd=0 on a bubble.
        @(negedge clk);
        drive(0, 1, 0, 1, 32'h5555_5555, 32'h3010, 0, 0, 1, 1);
        @(posedge clk);
        #1;
        check("keep1.pc", 64'(out_pc), 64'h3010);
        check("keep1.bd", 64'(out_bd), 64'd1);
        check("keep0.pc", 64'(k0_pc), 64'h3000);
        check("keep0.bd", 64'(k0_bd), 64'd0);
        check("keep0.valid", 64'(k0_valid), 64'd0);
        check("keep0.cnt", 64'(k0_cnt), 64'd1);

        // CNT_W=2 counter saturates at 3 over five consecutive bubbles.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bubble = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat%0d", i), 64'(c2_cnt), 64'((i < 3) ? i + 1 : 3));
        end
        @(negedge clk);
        bubble = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("sat.flush_keeps", 64'(c2_cnt), 64'd3);
        check("cnt16.after5", 64'(bubble_cnt), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core; replaces the per-boundary hand-written registers (F/D, D/E, E/M, M/W).
- Carries instruction, PC, exception code, delay-slot flag, a valid bit and an opaque sideband payload.
- Supports hold (stall), bubble insertion, exception/eret flush, and in-stage exception merging.
- Provides a saturating bubble counter for performance inspection.

Parameters:
- INS_W, 32, instruction width.
- PC_W, 32, PC width.
- EXTRA_W, 1, sideband payload width (forwarded unchanged; minimum 1).
- RESET_PC, 32'h0000_3000, out_pc value after reset.
- FLUSH_PC, 32'h0000_4180, out_pc value after flush.
- KEEP_PC_ON_BUBBLE, 1, 1 = a bubble keeps in_pc/in_bd so CP0 sees the macroscopic PC; 0 = a bubble loads RESET_PC and bd=0.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  hold all outputs.
- bubble  in  1  load a NOP instead of the input.
- flush  in  1  exception entry or eret; discard contents.
- in_valid  in  1  upstream slot holds a real instruction.
- in_ins  in  INS_W  instruction.
- in_pc  in  PC_W  PC of the instruction.
- in_exccode  in  5  exception code from earlier stages; 0 = none.
- in_bd  in  1  instruction is in a branch delay slot.
- in_extra  in  EXTRA_W  sideband payload.
- stage_exccode  in  5  exception detected in the producing stage; 0 = none.
- out_valid  out  1  registered valid.
- out_ins  out  INS_W  registered instruction.
- out_pc  out  PC_W  registered PC.
- out_exccode  out  5  registered merged exception code.
- out_bd  out  1  registered delay-slot flag.
- out_extra  out  EXTRA_W  registered sideband payload.
- bubble_cnt  out  CNT_W  count of bubbles inserted; saturating.

Behaviour:
- All state updates on posedge clk or posedge reset. Outputs come straight from registers. Latency is one cycle.
- Reset (asynchronous, takes effect immediately, no clock needed):
  - out_valid=0, out_ins=0, out_pc=RESET_PC, out_exccode=0, out_bd=0, out_extra=0, bubble_cnt=0.
- Per-edge priority, highest first: flush > stall > bubble > load.
- flush:
  - out_valid=0, out_ins=0, out_exccode=0, out_bd=0, out_extra=0, out_pc=FLUSH_PC.
  - stall and bubble are ignored in the same cycle.
- stall (no flush): every output and bubble_cnt holds its value, even if bubble=1.
- bubble (no flush, no stall):
  - out_valid=0, out_ins=0, out_exccode=0, out_extra=0.
  - KEEP_PC_ON_BUBBLE=1: out_pc=in_pc, out_bd=in_bd.
  - KEEP_PC_ON_BUBBLE=0: out_pc=RESET_PC, out_bd=0.
  - bubble_cnt increments by 1; it saturates at 2^CNT_W-1 and never wraps.
- load (none of flush, stall, bubble asserted):
  - out_valid=in_valid, out_ins=in_ins, out_pc=in_pc, out_bd=in_bd, out_extra=in_extra.
  - out_exccode=in_exccode if in_exccode!=0; otherwise stage_exccode.
  - An earlier-stage exception always has precedence over the in-stage one.
  - If in_valid=0, out_exccode=0 regardless of either code.
- bubble_cnt changes only on bubble-taken edges and on reset. Flush does not clear it.
- Reset asserted mid-stall or mid-flush: reset wins immediately. Deassertion gives normal operation from the next edge.
- No combinational path from any input to any output.

Test Plan:
- Reset, then assert reset again asynchronously between clock edges with out_ins=32'h1234_5678 loaded -> outputs drop at once to 0, out_pc=32'h0000_3000, bubble_cnt=0, with no clock edge required.
- Load in_valid=1, in_ins=32'h2408_0005, in_pc=32'h3004, in_bd=1, in_exccode=0, stage_exccode=10 -> next edge out_exccode=10, out_bd=1, out_pc=32'h3004. Repeat with in_exccode=4 -> out_exccode=4.
- Hold stall=1 for 3 edges while in_ins changes each cycle -> outputs are frozen at the pre-stall values. Also assert bubble=1 during the stall -> bubble_cnt unchanged.
- Assert bubble=1 with in_pc=32'h3010, in_bd=1 -> out_valid=0, out_ins=0, out_pc=32'h3010, out_bd=1, bubble_cnt+1. Repeat with KEEP_PC_ON_BUBBLE=0 -> out_pc=32'h3000, out_bd=0.
- Assert flush=1 together with stall=1 and bubble=1 -> out_pc=32'h0000_4180, all other fields 0, bubble_cnt unchanged.
- With CNT_W=2, insert 5 consecutive bubbles -> bubble_cnt reads 1,2,3,3,3.
